rr_arb2: RTL and testbench

RR_ARB2 -- requirements
Module: rr_arb2

---
 rtl/rr_arb2_if.sv | 47 ++++
 rtl/rr_arb2.sv | 124 ++++++++++++
 tb/tb_rr_arb2.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb2_if.sv
// Bundle for the two requester ports and the output port of rr_arb2.
// Optional build macro: RR_ARB2_LOCK_EN adds the l0/l1 "last beat" flags.
// Handshake: a beat moves on a port when its valid and ready are both high
// at a rising clk edge. Ready may depend on valid only through arbitration,
// and a valid requester may withdraw without a transfer.
interface rr_arb2_if #(
  parameter int N = 1
);
  logic [N-1:0] d0;
  logic         v0;
  logic         r0;
  logic [N-1:0] d1;
  logic         v1;
  logic         r1;
  logic [N-1:0] y;
  logic         yv;
  logic         yr;
  logic         ys;
`ifdef RR_ARB2_LOCK_EN
  logic         l0;
  logic         l1;

  // Arbiter side
  modport slave (
    input  d0, v0, d1, v1, yr, l0, l1,
    output r0, r1, y, yv, ys
  );

  // Requesters and downstream side
  modport master (
    output d0, v0, d1, v1, yr, l0, l1,
    input  r0, r1, y, yv, ys
  );
`else
  // Arbiter side
  modport slave (
    input  d0, v0, d1, v1, yr,
    output r0, r1, y, yv, ys
  );

  // Requesters and downstream side
  modport master (
    output d0, v0, d1, v1, yr,
    input  r0, r1, y, yv, ys
  );
`endif
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a one-deep registered output stage.
// Optional build macro: RR_ARB2_LOCK_EN holds the grant on one requester
// until it sends a beat with its last flag set (packet locking).
// dbg_pri_o shows the priority pointer; dbg_lock_o shows the lock state
// (0 = none, 1 = locked to requester 0, 2 = locked to requester 1).
module rr_arb2 #(
  parameter int N = 1
) (
  input  logic        clk,
  input  logic        reset,
  rr_arb2_if.slave    bus,
  output logic        dbg_pri_o,
  output logic [1:0]  dbg_lock_o
);

  logic         acc;
  logic         gnt_vld;
  logic         gnt;
  logic         xfer;
  logic         pri_q, pri_d;
  logic [N-1:0] y_q, y_d;
  logic         ys_q, ys_d;
  logic         yv_q, yv_d;

`ifdef RR_ARB2_LOCK_EN
  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_0    = 2'd1,
    LK_1    = 2'd2
  } lock_e;

  lock_e lock_q, lock_d;
  logic  last_sel;
`endif

  // The output register can take a new beat when empty or being drained.
  assign acc = !yv_q | bus.yr;

  // Grant selection: single requester wins outright, contention uses pri,
  // an active lock restricts the grant to the locked requester.
  always_comb begin
    gnt_vld = bus.v0 | bus.v1;
    gnt     = (bus.v0 & bus.v1) ? pri_q : bus.v1;
`ifdef RR_ARB2_LOCK_EN
    case (lock_q)
      LK_0: begin
        gnt_vld = bus.v0;
        gnt     = 1'b0;
      end
      LK_1: begin
        gnt_vld = bus.v1;
        gnt     = 1'b1;
      end
      default: ;
    endcase
`endif
  end

  // Ready is forced low during reset so nothing is accepted then.
  assign bus.r0 = !reset & acc & gnt_vld & !gnt;
  assign bus.r1 = !reset & acc & gnt_vld & gnt;
  assign xfer   = (bus.v0 & bus.r0) | (bus.v1 & bus.r1);

  // Next-state for output register, priority pointer and lock state.
  always_comb begin
    y_d   = y_q;
    ys_d  = ys_q;
    yv_d  = yv_q;
    pri_d = pri_q;
`ifdef RR_ARB2_LOCK_EN
    lock_d   = lock_q;
    last_sel = gnt ? bus.l1 : bus.l0;
`endif
    if (xfer) begin
      y_d   = gnt ? bus.d1 : bus.d0;
      ys_d  = gnt;
      yv_d  = 1'b1;
      pri_d = !gnt;
`ifdef RR_ARB2_LOCK_EN
      if (!last_sel) begin
        // Mid-packet beat: stick to this source, pointer untouched.
        lock_d = gnt ? LK_1 : LK_0;
        pri_d  = pri_q;
      end else begin
        lock_d = LK_NONE;
      end
`endif
    end else if (yv_q & bus.yr) begin
      yv_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q   <= '0;
      ys_q  <= 1'b0;
      yv_q  <= 1'b0;
      pri_q <= 1'b0;
`ifdef RR_ARB2_LOCK_EN
      lock_q <= LK_NONE;
`endif
    end else begin
      y_q   <= y_d;
      ys_q  <= ys_d;
      yv_q  <= yv_d;
      pri_q <= pri_d;
`ifdef RR_ARB2_LOCK_EN
      lock_q <= lock_d;
`endif
    end
  end

  assign bus.y     = y_q;
  assign bus.ys    = ys_q;
  assign bus.yv    = yv_q;
  assign dbg_pri_o = pri_q;
`ifdef RR_ARB2_LOCK_EN
  assign dbg_lock_o = lock_q;
`else
  assign dbg_lock_o = 2'b00;
`endif

endmodule

// File: tb/tb_rr_arb2.sv
// Directed bench for rr_arb2 with N = 8.
module tb_rr_arb2;

  localparam int N = 8;

  logic       clk;
  logic       reset;
  logic       dbg_pri;
  logic [1:0] dbg_lock;
  int         tests_run;
  int         tests_failed;

  rr_arb2_if #(.N(N)) bus ();

  rr_arb2 #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .dbg_pri_o  (dbg_pri),
    .dbg_lock_o (dbg_lock)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.d0 = '0; bus.v0 = 1'b0;
    bus.d1 = '0; bus.v1 = 1'b0;
    bus.yr = 1'b0;
`ifdef RR_ARB2_LOCK_EN
    bus.l0 = 1'b1; bus.l1 = 1'b1;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Two reset cycles with requests pending: nothing accepted, outputs zero.
  task automatic test_reset();
    clear_inputs();
    bus.v0 = 1'b1; bus.v1 = 1'b1; bus.yr = 1'b1;
    bus.d0 = 8'h77; bus.d1 = 8'h66;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if ({bus.r0, bus.r1} !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_ready cyc%0d: got r0r1=%b want 00", i, {bus.r0, bus.r1});
      end
      tick();
      tests_run++;
      if (bus.yv !== 1'b0 || bus.y !== 8'h00 || bus.ys !== 1'b0 || dbg_pri !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_out cyc%0d: got yv=%b y=%h ys=%b pri=%b want 0 00 0 0",
                 i, bus.yv, bus.y, bus.ys, dbg_pri);
      end
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  // Lone requester 0: immediate ready, one-cycle latency, then drain.
  task automatic test_single();
    do_reset();
    bus.v0 = 1'b1; bus.d0 = 8'hA5; bus.yr = 1'b1;
    #1;
    tests_run++;
    if ({bus.r0, bus.r1} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_ready: got r0r1=%b want 10", {bus.r0, bus.r1});
    end
    tick();
    bus.v0 = 1'b0;
    tests_run++;
    if (bus.y !== 8'hA5 || bus.ys !== 1'b0 || bus.yv !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_out: got y=%h ys=%b yv=%b want a5 0 1", bus.y, bus.ys, bus.yv);
    end
    tick();
    tests_run++;
    if (bus.yv !== 1'b0 || bus.y !== 8'hA5 || dbg_pri !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_drain: got yv=%b y=%h pri=%b want 0 a5 1", bus.yv, bus.y, dbg_pri);
    end
    // Lone requester 1 after that is granted regardless of pointer.
    bus.v1 = 1'b1; bus.d1 = 8'h3C;
    #1;
    tests_run++;
    if ({bus.r0, bus.r1} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single1_ready: got r0r1=%b want 01", {bus.r0, bus.r1});
    end
    tick();
    bus.v1 = 1'b0;
    tests_run++;
    if (bus.y !== 8'h3C || bus.ys !== 1'b1 || bus.yv !== 1'b1 || dbg_pri !== 1'b0) begin
      tests_failed++;
      $display("FAIL single1_out: got y=%h ys=%b yv=%b pri=%b want 3c 1 1 0",
               bus.y, bus.ys, bus.yv, dbg_pri);
    end
  endtask

  // Both requesting continuously: strict alternation starting with 0.
  task automatic test_alternate();
    logic [7:0] exp_y [4];
    logic       exp_s [4];
    exp_y = '{8'h11, 8'h22, 8'h11, 8'h22};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus.v0 = 1'b1; bus.d0 = 8'h11;
    bus.v1 = 1'b1; bus.d1 = 8'h22;
    bus.yr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (bus.r0 !== !exp_s[i] || bus.r1 !== exp_s[i]) begin
        tests_failed++;
        $display("FAIL alt_ready beat%0d: got r0r1=%b%b want %b%b",
                 i, bus.r0, bus.r1, !exp_s[i], exp_s[i]);
      end
      tick();
      tests_run++;
      if (bus.y !== exp_y[i] || bus.ys !== exp_s[i] || bus.yv !== 1'b1) begin
        tests_failed++;
        $display("FAIL alt_out beat%0d: got y=%h ys=%b yv=%b want %h %b 1",
                 i, bus.y, bus.ys, bus.yv, exp_y[i], exp_s[i]);
      end
    end
  endtask

  // Downstream stall with both valid: output frozen, no ready, then resume.
  task automatic test_stall();
    bus.yr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({bus.r0, bus.r1} !== 2'b00) begin
        tests_failed++;
        $display("FAIL stall_ready cyc%0d: got r0r1=%b want 00", i, {bus.r0, bus.r1});
      end
      tick();
      tests_run++;
      if (bus.y !== 8'h22 || bus.ys !== 1'b1 || bus.yv !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold cyc%0d: got y=%h ys=%b yv=%b want 22 1 1",
                 i, bus.y, bus.ys, bus.yv);
      end
    end
    bus.yr = 1'b1;
    tick();
    tests_run++;
    if (bus.y !== 8'h11 || bus.ys !== 1'b0 || bus.yv !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_resume: got y=%h ys=%b yv=%b want 11 0 1", bus.y, bus.ys, bus.yv);
    end
    bus.v0 = 1'b0; bus.v1 = 1'b0;
    tick();
    tests_run++;
    if (bus.yv !== 1'b0 || bus.y !== 8'h11 || bus.ys !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_drain: got yv=%b y=%h ys=%b want 0 11 0", bus.yv, bus.y, bus.ys);
    end
  endtask

  // Request withdrawn while stalled: no state change.
  task automatic test_withdraw();
    // pri is 1 here (last transfer from requester 0).
    bus.yr = 1'b1; bus.v0 = 1'b1; bus.d0 = 8'h5A;
    tick();
    bus.v0 = 1'b0; bus.yr = 1'b0;
    bus.v1 = 1'b1; bus.d1 = 8'hC3;
    tick();
    bus.v1 = 1'b0;
    tick();
    tests_run++;
    if (bus.y !== 8'h5A || bus.ys !== 1'b0 || bus.yv !== 1'b1 || dbg_pri !== 1'b1) begin
      tests_failed++;
      $display("FAIL withdraw: got y=%h ys=%b yv=%b pri=%b want 5a 0 1 1",
               bus.y, bus.ys, bus.yv, dbg_pri);
    end
  endtask

  // Reset while a beat is held: beat discarded, pointer back to 0.
  task automatic test_reset_mid();
    // Still holding 0x5A with yr=0 and pri=1.
    reset = 1'b1;
    bus.v0 = 1'b1; bus.v1 = 1'b1; bus.d0 = 8'h33; bus.d1 = 8'h44;
    #1;
    tests_run++;
    if ({bus.r0, bus.r1} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rstmid_ready: got r0r1=%b want 00", {bus.r0, bus.r1});
    end
    tick();
    reset = 1'b0;
    tests_run++;
    if (bus.yv !== 1'b0 || bus.y !== 8'h00 || dbg_pri !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_out: got yv=%b y=%h pri=%b want 0 00 0", bus.yv, bus.y, dbg_pri);
    end
    // First arbitration after reset favours requester 0.
    #1;
    tests_run++;
    if ({bus.r0, bus.r1} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rstmid_first_ready: got r0r1=%b want 10", {bus.r0, bus.r1});
    end
    tick();
    tests_run++;
    if (bus.y !== 8'h33 || bus.ys !== 1'b0 || bus.yv !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_first_out: got y=%h ys=%b yv=%b want 33 0 1", bus.y, bus.ys, bus.yv);
    end
    clear_inputs();
  endtask

`ifdef RR_ARB2_LOCK_EN
  // Three-beat packet from requester 0 holds the grant until its last beat.
  task automatic test_lock();
    logic [7:0] beat [3];
    logic       last [3];
    logic [1:0] exp_lk [3];
    logic       exp_pri [3];
    beat    = '{8'h01, 8'h02, 8'h03};
    last    = '{1'b0, 1'b0, 1'b1};
    exp_lk  = '{2'd1, 2'd1, 2'd0};
    exp_pri = '{1'b0, 1'b0, 1'b1};
    do_reset();
    bus.v0 = 1'b1; bus.v1 = 1'b1; bus.d1 = 8'h99; bus.l1 = 1'b1; bus.yr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.d0 = beat[i]; bus.l0 = last[i];
      #1;
      tests_run++;
      if ({bus.r0, bus.r1} !== 2'b10) begin
        tests_failed++;
        $display("FAIL lock_ready beat%0d: got r0r1=%b want 10", i, {bus.r0, bus.r1});
      end
      tick();
      tests_run++;
      if (bus.y !== beat[i] || bus.ys !== 1'b0 || dbg_lock !== exp_lk[i] || dbg_pri !== exp_pri[i]) begin
        tests_failed++;
        $display("FAIL lock_out beat%0d: got y=%h ys=%b lk=%0d pri=%b want %h 0 %0d %b",
                 i, bus.y, bus.ys, dbg_lock, dbg_pri, beat[i], exp_lk[i], exp_pri[i]);
      end
    end
    tick();
    tests_run++;
    if (bus.y !== 8'h99 || bus.ys !== 1'b1 || bus.yv !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_release: got y=%h ys=%b yv=%b want 99 1 1", bus.y, bus.ys, bus.yv);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_withdraw();
    test_reset_mid();
`ifdef RR_ARB2_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
